// File: rtl/sync_dp_ram_arb_pkg.sv
// Shared types and helpers for the round-robin dual-port RAM arbiter.
// Optional read forwarding is controlled by SYNC_DP_RAM_ARB_RD_FWD_EN.
package sync_dp_ram_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  localparam int unsigned TAG_IDX_W  = 4;   // enough for 16 requesters
  localparam int unsigned TAG_DATA_W = 64;  // widest supported word

  typedef struct packed {
    logic                  valid;
    logic [TAG_IDX_W-1:0]  req_idx;
    logic                  fwd;
    logic [TAG_DATA_W-1:0] fwd_data;
  } tag_t;

  function automatic logic [TAG_IDX_W-1:0] rr_next(input logic [TAG_IDX_W-1:0] last_idx,
                                                   input int unsigned           num_req);
    if (32'(last_idx) + 32'd1 >= num_req) return '0;
    return last_idx + 1'b1;
  endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// True dual-port synchronous RAM, read-first on both ports, optional output register.
// Read data is zero on any cycle the port did not perform a read.
module sync_dp_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  CSelA_SI,
  input  logic                  WrEnA_SI,
  input  logic [ADDR_WIDTH-1:0] AddrA_DI,
  input  logic [DATA_WIDTH-1:0] WrDataA_DI,
  output logic [DATA_WIDTH-1:0] RdDataA_DO,
  input  logic                  CSelB_SI,
  input  logic                  WrEnB_SI,
  input  logic [ADDR_WIDTH-1:0] AddrB_DI,
  input  logic [DATA_WIDTH-1:0] WrDataB_DI,
  output logic [DATA_WIDTH-1:0] RdDataB_DO
);

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_a;
  logic [DATA_WIDTH-1:0] r_rd_b;

  // Contents survive reset; only the read path is cleared.
  always_ff @(posedge Clk_CI) begin
    if (CSelA_SI && WrEnA_SI) r_mem[AddrA_DI] <= WrDataA_DI;
    if (CSelB_SI && WrEnB_SI) r_mem[AddrB_DI] <= WrDataB_DI;
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= (CSelA_SI && !WrEnA_SI) ? r_mem[AddrA_DI] : '0;
      r_rd_b <= (CSelB_SI && !WrEnB_SI) ? r_mem[AddrB_DI] : '0;
    end
  end

  if (OUT_REGS != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
        r_out_a <= '0;
        r_out_b <= '0;
      end else begin
        r_out_a <= r_rd_a;
        r_out_b <= r_rd_b;
      end
    end
    assign RdDataA_DO = r_out_a;
    assign RdDataB_DO = r_out_b;
  end else begin : g_noreg
    assign RdDataA_DO = r_rd_a;
    assign RdDataB_DO = r_rd_b;
  end

endmodule

// File: rtl/sync_dp_ram_arb.sv
// Round-robin arbiter granting up to two requesters per cycle onto a dual-port RAM.
// Define SYNC_DP_RAM_ARB_RD_FWD_EN to forward same-cycle opposite-port write data to reads.
module sync_dp_ram_arb
  import sync_dp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                                 Clk_CI,
  input  logic                                 Rst_RBI,
  input  logic [NUM_REQ-1:0]                   Req_SI,
  input  logic [NUM_REQ-1:0]                   WrEn_SI,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   Addr_DI,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   WrData_DI,
  output logic [NUM_REQ-1:0]                   Gnt_SO,
  output logic [NUM_REQ-1:0]                   RdValid_SO,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   RdData_DO,
  output logic                                 AddrErr_SO
);

  localparam int unsigned LAT   = 1 + OUT_REGS;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]      r_ptr;
  logic                  r_addr_err;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_cand;
  logic [IDX_W-1:0]      w_last;
  logic                  w_vld    [2];
  logic [IDX_W-1:0]      w_idx    [2];
  logic [ADDR_WIDTH-1:0] w_addr   [2];
  logic                  w_we     [2];
  logic                  w_oor    [2];
  logic                  w_csel   [2];
  logic [DATA_WIDTH-1:0] w_wdata  [2];
  logic [DATA_WIDTH-1:0] w_ram_rd [2];
  logic [DATA_WIDTH-1:0] w_resp   [2];
  tag_t                  w_tail   [2];

  function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned     k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Circular scan: first requester takes A, next compatible one takes B.
  always_comb begin
    w_gnt        = '0;
    w_cand       = '0;
    w_vld[PORT_A] = 1'b0;
    w_vld[PORT_B] = 1'b0;
    w_idx[PORT_A] = '0;
    w_idx[PORT_B] = '0;
    if (Rst_RBI) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = scan_idx(r_ptr, k);
        if (Req_SI[w_cand]) begin
          if (!w_vld[PORT_A]) begin
            w_vld[PORT_A] = 1'b1;
            w_idx[PORT_A] = w_cand;
          end else if (!w_vld[PORT_B] &&
                       !(WrEn_SI[w_idx[PORT_A]] && WrEn_SI[w_cand] &&
                         (Addr_DI[w_idx[PORT_A]] == Addr_DI[w_cand]))) begin
            w_vld[PORT_B] = 1'b1;
            w_idx[PORT_B] = w_cand;
          end
        end
      end
      if (w_vld[PORT_A]) w_gnt[w_idx[PORT_A]] = 1'b1;
      if (w_vld[PORT_B]) w_gnt[w_idx[PORT_B]] = 1'b1;
    end
  end

  assign Gnt_SO = w_gnt;
  assign w_last = w_vld[PORT_B] ? w_idx[PORT_B] : w_idx[PORT_A];

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_ptr      <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_vld[PORT_A]) r_ptr <= IDX_W'(rr_next(TAG_IDX_W'(w_last), NUM_REQ));
      r_addr_err <= (w_vld[PORT_A] & w_oor[PORT_A]) | (w_vld[PORT_B] & w_oor[PORT_B]);
    end
  end

  assign AddrErr_SO = r_addr_err;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam int OTH = 1 - gi;
    tag_t w_new_tag;
    tag_t r_tag [LAT];

    assign w_addr[gi]  = Addr_DI[w_idx[gi]];
    assign w_we[gi]    = WrEn_SI[w_idx[gi]];
    assign w_wdata[gi] = WrData_DI[w_idx[gi]];
    // Out-of-range requests are granted but never touch the RAM.
    assign w_oor[gi]   = ({1'b0, w_addr[gi]} >= (ADDR_WIDTH+1)'(DATA_DEPTH));
    assign w_csel[gi]  = w_vld[gi] & ~w_oor[gi];

`ifdef SYNC_DP_RAM_ARB_RD_FWD_EN
    logic w_fwd;
    assign w_fwd = w_csel[gi] & ~w_we[gi] & w_csel[OTH] & w_we[OTH] &
                   (w_addr[gi] == w_addr[OTH]);
    assign w_new_tag = '{valid:    w_vld[gi] & ~w_we[gi],
                         req_idx:  TAG_IDX_W'(w_idx[gi]),
                         fwd:      w_fwd,
                         fwd_data: TAG_DATA_W'(w_wdata[OTH])};
    assign w_resp[gi] = w_tail[gi].fwd ? w_tail[gi].fwd_data[DATA_WIDTH-1:0] : w_ram_rd[gi];
`else
    assign w_new_tag = '{valid:    w_vld[gi] & ~w_we[gi],
                         req_idx:  TAG_IDX_W'(w_idx[gi]),
                         fwd:      1'b0,
                         fwd_data: '0};
    assign w_resp[gi] = w_ram_rd[gi];
`endif

    always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
        for (int s = 0; s < LAT; s++) r_tag[s] <= '0;
      end else begin
        r_tag[0] <= w_new_tag;
        for (int s = 1; s < LAT; s++) r_tag[s] <= r_tag[s-1];
      end
    end

    assign w_tail[gi] = r_tag[LAT-1];
  end

  // The two ports never carry tags for the same requester in one cycle.
  always_comb begin
    RdValid_SO = '0;
    RdData_DO  = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_tail[p].valid) begin
        RdValid_SO[w_tail[p].req_idx[IDX_W-1:0]] = 1'b1;
        RdData_DO[w_tail[p].req_idx[IDX_W-1:0]]  = w_resp[p];
      end
    end
  end

  sync_dp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REGS   (OUT_REGS)
  ) i_ram (
    .Clk_CI     (Clk_CI),
    .Rst_RBI    (Rst_RBI),
    .CSelA_SI   (w_csel[PORT_A]),
    .WrEnA_SI   (w_we[PORT_A]),
    .AddrA_DI   (w_addr[PORT_A]),
    .WrDataA_DI (w_wdata[PORT_A]),
    .RdDataA_DO (w_ram_rd[PORT_A]),
    .CSelB_SI   (w_csel[PORT_B]),
    .WrEnB_SI   (w_we[PORT_B]),
    .AddrB_DI   (w_addr[PORT_B]),
    .WrDataB_DI (w_wdata[PORT_B]),
    .RdDataB_DO (w_ram_rd[PORT_B])
  );

endmodule

// File: tb/tb_sync_dp_ram_arb.sv
// Directed bench for sync_dp_ram_arb (DATA_DEPTH=1000, OUT_REGS=1, so read latency 2).
// Expected forwarding result follows SYNC_DP_RAM_ARB_RD_FWD_EN.
module tb_sync_dp_ram_arb;

  localparam int NR    = 4;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int OREGS = 1;

`ifdef SYNC_DP_RAM_ARB_RD_FWD_EN
  localparam logic [31:0] FWD_EXP = 32'h0000_A5A5;
`else
  localparam logic [31:0] FWD_EXP = 32'h0000_0000;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req, we, gnt, rdv;
  logic [NR-1:0][AW-1:0]  addr;
  logic [NR-1:0][DW-1:0]  wdata, rdata;
  logic                   aerr;
  int                     errors = 0;
  int                     checks = 0;

  always #5 clk = ~clk;

  sync_dp_ram_arb #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_DEPTH (DEPTH),
    .DATA_WIDTH (DW),
    .OUT_REGS   (OREGS)
  ) dut (
    .Clk_CI     (clk),
    .Rst_RBI    (rst_n),
    .Req_SI     (req),
    .WrEn_SI    (we),
    .Addr_DI    (addr),
    .WrData_DI  (wdata),
    .Gnt_SO     (gnt),
    .RdValid_SO (rdv),
    .RdData_DO  (rdata),
    .AddrErr_SO (aerr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr();
    req = '0;
    we  = '0;
  endtask

  task automatic set_rq(input int i, input logic w, input int a, input logic [31:0] d);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = AW'(a);
    wdata[i] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("ok   %-12s obs=%0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;

    // reset with requests pending
    req = 4'hF; settle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    tick(); tick(); settle();
    chk("rst_rdv", 32'(rdv), 32'h0);
    chk("rst_aerr", 32'(aerr), 32'h0);
    chk("rst_rdata0", rdata[0], 32'h0);
    tick(); rst_n = 1'b1; clr(); settle();

    // preload addresses 0..3
    tick(); for (int i = 0; i < NR; i++) set_rq(i, 1'b1, i, 32'h100 + 32'(i)); settle();
    chk("pre_gnt0", 32'(gnt), 32'h3);
    tick(); req[0] = 1'b0; req[1] = 1'b0; settle();
    chk("pre_gnt1", 32'(gnt), 32'hC);
    tick(); clr(); settle();
    chk("pre_rdv0", 32'(rdv), 32'h0);
    tick(); settle();
    chk("pre_rdv1", 32'(rdv), 32'h0);

    // four reads: two per cycle, responses at latency 2
    tick(); for (int i = 0; i < NR; i++) set_rq(i, 1'b0, i, 32'h0); settle();
    chk("t1_gnt0", 32'(gnt), 32'h3);
    tick(); req[0] = 1'b0; req[1] = 1'b0; settle();
    chk("t1_gnt1", 32'(gnt), 32'hC);
    chk("t1_rdv_c1", 32'(rdv), 32'h0);
    tick(); clr(); settle();
    chk("t1_rdv_c2", 32'(rdv), 32'h3);
    chk("t1_rd0", rdata[0], 32'h100);
    chk("t1_rd1", rdata[1], 32'h101);
    tick(); settle();
    chk("t1_rdv_c3", 32'(rdv), 32'hC);
    chk("t1_rd2", rdata[2], 32'h102);
    chk("t1_rd3", rdata[3], 32'h103);
    tick(); settle();
    chk("t1_rdv_c4", 32'(rdv), 32'h0);

    // two writes to the same address: only one granted per cycle
    tick(); set_rq(1, 1'b1, 5, 32'hDEAD_BEEF); set_rq(2, 1'b1, 5, 32'h1234); settle();
    chk("ww_gnt0", 32'(gnt), 32'h2);
    tick(); req[1] = 1'b0; settle();
    chk("ww_gnt1", 32'(gnt), 32'h4);
    tick(); clr(); set_rq(0, 1'b0, 5, 32'h0); settle();
    chk("ww_rd_gnt", 32'(gnt), 32'h1);
    tick(); clr(); settle();
    tick(); settle();
    chk("ww_rdv", 32'(rdv), 32'h1);
    chk("ww_rd5", rdata[0], 32'h1234);

    // pointer at 1 -> req2 moves it to 3, then wrap grants req3 on A and req0 on B
    tick(); clr(); set_rq(2, 1'b0, 2, 32'h0); settle();
    chk("rr_gnt0", 32'(gnt), 32'h4);
    tick(); clr(); set_rq(3, 1'b0, 3, 32'h0); set_rq(0, 1'b0, 0, 32'h0); settle();
    chk("rr_wrap", 32'(gnt), 32'h9);
    tick(); clr(); for (int i = 0; i < NR; i++) set_rq(i, 1'b0, i, 32'h0); settle();
    chk("rr_ptr1", 32'(gnt), 32'h6);
    chk("rr_rdv2", 32'(rdv), 32'h4);
    chk("rr_rd2", rdata[2], 32'h102);
    tick(); req[1] = 1'b0; req[2] = 1'b0; settle();
    chk("rr_gnt3", 32'(gnt), 32'h9);
    chk("rr_rdv3", 32'(rdv), 32'h9);
    chk("rr_rd3", rdata[3], 32'h103);
    chk("rr_rd0", rdata[0], 32'h100);
    tick(); clr(); settle();
    chk("rr_rdv4", 32'(rdv), 32'h6);
    chk("rr_rd1", rdata[1], 32'h101);
    tick(); settle();
    chk("rr_rdv5", 32'(rdv), 32'h9);

    // same-cycle write (A) and read (B) of address 7
    tick(); clr(); set_rq(1, 1'b1, 7, 32'h0); settle();
    chk("rw_gnt0", 32'(gnt), 32'h2);
    chk("rw_rdv0", 32'(rdv), 32'h0);
    tick(); clr(); set_rq(0, 1'b1, 7, 32'hA5A5); set_rq(1, 1'b0, 7, 32'h0); settle();
    chk("rw_gnt1", 32'(gnt), 32'h3);
    tick(); clr(); settle();
    tick(); settle();
    chk("rw_rdv", 32'(rdv), 32'h2);
    chk("rw_rd7", rdata[1], FWD_EXP);
    tick(); set_rq(3, 1'b0, 7, 32'h0); settle();
    chk("rw_gnt2", 32'(gnt), 32'h8);
    tick(); clr(); settle();
    tick(); settle();
    chk("rw_rdv2", 32'(rdv), 32'h8);
    chk("rw_rd7new", rdata[3], 32'hA5A5);

    // out-of-range read
    tick(); set_rq(0, 1'b0, 1023, 32'h0); settle();
    chk("oor_gnt", 32'(gnt), 32'h1);
    chk("oor_aerr0", 32'(aerr), 32'h0);
    tick(); clr(); settle();
    chk("oor_aerr1", 32'(aerr), 32'h1);
    chk("oor_rdv1", 32'(rdv), 32'h0);
    tick(); settle();
    chk("oor_aerr2", 32'(aerr), 32'h0);
    chk("oor_rdv2", 32'(rdv), 32'h1);
    chk("oor_rd", rdata[0], 32'h0);

    // reset while reads are in flight
    tick(); for (int i = 0; i < NR; i++) set_rq(i, 1'b0, i, 32'h0); settle();
    chk("mr_gnt0", 32'(gnt), 32'h6);
    tick(); rst_n = 1'b0; req[1] = 1'b0; req[2] = 1'b0; settle();
    chk("mr_gnt_rst", 32'(gnt), 32'h0);
    chk("mr_rdv1", 32'(rdv), 32'h0);
    tick(); rst_n = 1'b1; clr(); settle();
    chk("mr_rdv2", 32'(rdv), 32'h0);
    tick(); settle();
    chk("mr_rdv3", 32'(rdv), 32'h0);
    tick(); set_rq(0, 1'b0, 5, 32'h0); for (int i = 1; i < NR; i++) set_rq(i, 1'b0, i, 32'h0); settle();
    chk("mr_gnt_restart", 32'(gnt), 32'h3);
    tick(); req[0] = 1'b0; req[1] = 1'b0; settle();
    chk("mr_gnt1", 32'(gnt), 32'hC);
    tick(); clr(); settle();
    chk("mr_rdv_a", 32'(rdv), 32'h3);
    chk("mr_rd5", rdata[0], 32'h1234);
    chk("mr_rd1", rdata[1], 32'h101);
    tick(); settle();
    chk("mr_rdv_b", 32'(rdv), 32'hC);
    chk("mr_rd3", rdata[3], 32'h103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_dp_ram_arb.md
Name: sync_dp_ram_arb

Overview:
- Round-robin arbiter that shares one dual-port synchronous RAM between NUM_REQ requesters.
- Grants up to two requests per cycle, one on port A and one on port B.
- Never issues two same-cycle writes to the same address; routes read data back to the issuing requester.
- Sits between cluster-side masters (DMA, cores, debug) and the FPGA-inferred RAM; owns the RAM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 10, RAM address width.
- DATA_DEPTH, 1024, number of RAM words; must be <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- OUT_REGS, 0, RAM output register stages (0 or 1); sets read latency.

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  synchronous active-low reset.
- Req_SI  in  NUM_REQ  request valid, one bit per requester.
- WrEn_SI  in  NUM_REQ  1 = write, 0 = read.
- Addr_DI  in  NUM_REQ x ADDR_WIDTH  word address.
- WrData_DI  in  NUM_REQ x DATA_WIDTH  write data.
- Gnt_SO  out  NUM_REQ  grant; combinational, same cycle as the request.
- RdValid_SO  out  NUM_REQ  read response valid, one-cycle pulse.
- RdData_DO  out  NUM_REQ x DATA_WIDTH  read data, valid only with RdValid_SO.
- AddrErr_SO  out  1  one-cycle pulse: a granted request had Addr >= DATA_DEPTH.

Behaviour:
- Clock and reset: one clock, Clk_CI. Rst_RBI is a synchronous, active-low reset.
- Reset values: RR pointer 0; all tag pipelines invalid; Gnt_SO 0 while Rst_RBI low; RdValid_SO 0; RdData_DO 0; AddrErr_SO 0.
- Handshake: a request transfers when Req and Gnt are both high. Requester holds Req, WrEn, Addr and WrData stable until granted. Gnt never asserts without Req.
- Arbitration, each cycle:
  - Scan requesters circularly, starting at the RR pointer.
  - First active requester gets port A.
  - Next active requester gets port B, unless both are writes to the same address. In that case it is skipped and the scan continues.
  - At most 2 grants per cycle.
- RR pointer update: moves to (index of last granted requester + 1) mod NUM_REQ. Unchanged when nothing is granted.
- Out-of-range address: request is granted with CSel forced low, so there is no RAM access. AddrErr_SO pulses next cycle. A read still gets RdValid with RdData 0 at normal latency, so no requester hangs.
- Read latency: LAT = 1 + OUT_REGS cycles from grant to RdValid.
- Response routing:
  - Per port, a LAT-deep shift register carries {valid, requester index}.
  - The tag at the tail steers that port's RAM read data to the owning requester.
  - A and B never target the same requester in one cycle.
  - Writes produce no response.
- Same-cycle read and write to the same address on different ports, feature off: read returns the old memory content.
- Reset mid-operation: in-flight tags are cleared, so responses due are dropped. The RAM contents are not cleared.
- Pipelining: back-to-back grants to the same requester are allowed every cycle. Responses return in issue order.

Optional Feature:
- Macro: SYNC_DP_RAM_ARB_RD_FWD_EN.
- Defined: when a same-cycle read and write hit the same address on opposite ports, the read response carries the new write data. A forward flag and the data are registered alongside the tag and muxed at the tail.
- Undefined: the read returns the old data, which is native RAM behaviour. No extra registers.

Decomposition:
- Package sync_dp_ram_arb_pkg holds:
  - typedef port_sel_e {PORT_A, PORT_B};
  - a tag struct {valid, req_idx, fwd, fwd_data};
  - function rr_next().
- Sub-module: sync_dp_ram, instantiated once with identical parameters. Rst_RBI goes to its reset input.
- Arbiter, tag pipelines and response demux stay in the top module.

Test Plan:
- Reset, then Req_SI=4'b1111, all reads, addrs 0..3 → Gnt 4'b0011 at cycle 0, then 4'b1100 at cycle 1. RdValid for req0 and req1 at cycle LAT, for req2 and req3 at cycle 1+LAT, with correct data.
- req1 writes 0xDEAD_BEEF to addr 5 and req2 writes 0x1234 to addr 5, same cycle, pointer 0 → only req1 granted. req2 granted next cycle. A later read of addr 5 returns 0x1234.
- Pointer 3, Req_SI=4'b1001 → grants to req3 (port A) and req0 (port B). Pointer becomes 1.
- req0 writes 0xA5A5 to addr 7 while req1 reads addr 7, old value 0x0 → RdData 0x0 without the macro, 0xA5A5 with SYNC_DP_RAM_ARB_RD_FWD_EN.
- Read addr 1023 with DATA_DEPTH=1000 → granted, AddrErr_SO pulses next cycle, RdValid with data 0 at LAT.
- Reads in flight with OUT_REGS=1, then Rst_RBI low for 1 cycle → no RdValid follows. Grants restart from req0.
